// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_e;

    localparam int DEF_MAX_BURST = 4;
    localparam int STAT_W        = 16;
    localparam int BURST_W       = 4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                  input logic              en);
        if (en && (v != {STAT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating grant/conflict counters for the data-memory arbiter.
// Only instantiated when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_gnt,
    input  logic              r1_gnt,
    input  logic              conflict,
    output logic [STAT_W-1:0] r0_grant_cnt,
    output logic [STAT_W-1:0] r1_grant_cnt,
    output logic [STAT_W-1:0] conflict_cnt
);

    logic [STAT_W-1:0] r0_cnt_q, r0_cnt_d;
    logic [STAT_W-1:0] r1_cnt_q, r1_cnt_d;
    logic [STAT_W-1:0] cf_cnt_q, cf_cnt_d;

    // Next-count: each counter advances on its event and holds at 0xFFFF.
    always_comb begin
        r0_cnt_d = sat_inc(r0_cnt_q, r0_gnt);
        r1_cnt_d = sat_inc(r1_cnt_q, r1_gnt);
        cf_cnt_d = sat_inc(cf_cnt_q, conflict);
    end

    // Counter registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r0_cnt_q <= '0;
            r1_cnt_q <= '0;
            cf_cnt_q <= '0;
        end else begin
            r0_cnt_q <= r0_cnt_d;
            r1_cnt_q <= r1_cnt_d;
            cf_cnt_q <= cf_cnt_d;
        end
    end

    assign r0_grant_cnt = r0_cnt_q;
    assign r1_grant_cnt = r1_cnt_q;
    assign conflict_cnt = cf_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// The core wins by default; the loader is served after MAX_BURST contested
// core grants. Define DMEM_ARB_STATS_EN to add grant/conflict counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [STAT_W-1:0] r0_grant_cnt,
    output logic [STAT_W-1:0] r1_grant_cnt,
    output logic [STAT_W-1:0] conflict_cnt,
`endif
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               rv0_q, rv1_q;
    req_id_e            winner;
    logic               gnt_any;

    // Grant decision: core first unless the loader has waited MAX_BURST grants.
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        winner = REQ_CORE;
        if (reset) begin
            if (r0_req && (!r1_req || (burst_cnt_q < MAX_BURST_C))) begin
                r0_gnt = 1'b1;
            end else if (r1_req) begin
                r1_gnt = 1'b1;
                winner = REQ_LOADER;
            end
        end
    end

    assign gnt_any = r0_gnt | r1_gnt;

    // Memory port mux: winner's address/data/direction, all zero when idle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_any) begin
            case (winner)
                REQ_CORE: begin
                    mem_addr  = r0_addr;
                    mem_wdata = r0_wdata;
                    mem_write = r0_we;
                    mem_read  = ~r0_we;
                end
                default: begin
                    mem_addr  = r1_addr;
                    mem_wdata = r1_wdata;
                    mem_write = r1_we;
                    mem_read  = ~r1_we;
                end
            endcase
        end
    end

    // Burst counter: counts contested core grants, restarts whenever the
    // loader is served or stops asking, and never passes MAX_BURST.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!r1_req || r1_gnt) begin
            burst_cnt_d = '0;
        end else if (r0_gnt && (burst_cnt_q < MAX_BURST_C)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    // Burst counter and read-return pipeline flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_cnt_q <= '0;
            rv0_q       <= 1'b0;
            rv1_q       <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            rv0_q       <= r0_gnt & ~r0_we;
            rv1_q       <= r1_gnt & ~r1_we;
        end
    end

    // Read data is steered to whichever requester owns the returning read.
    assign r0_rvalid = rv0_q & reset;
    assign r1_rvalid = rv1_q & reset;
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats u_stats (
        .clk          (clk),
        .reset        (reset),
        .r0_gnt       (r0_gnt),
        .r1_gnt       (r1_gnt),
        .conflict     (r0_req & r1_req),
        .r0_grant_cnt (r0_grant_cnt),
        .r1_grant_cnt (r1_grant_cnt),
        .conflict_cnt (conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural registered memory.
// Stats checks are included when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       r0_req = 1'b0, r0_we = 1'b0;
    logic [7:0] r0_addr = '0, r0_wdata = '0;
    logic       r0_gnt, r0_rvalid;
    logic [7:0] r0_rdata;
    logic       r1_req = 1'b0, r1_we = 1'b0;
    logic [7:0] r1_addr = '0, r1_wdata = '0;
    logic       r1_gnt, r1_rvalid;
    logic [7:0] r1_rdata;
    logic       mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r0_grant_cnt, r1_grant_cnt, conflict_cnt;
`endif

    logic [7:0] mem_m [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .r0_req     (r0_req),
        .r0_we      (r0_we),
        .r0_addr    (r0_addr),
        .r0_wdata   (r0_wdata),
        .r0_gnt     (r0_gnt),
        .r0_rvalid  (r0_rvalid),
        .r0_rdata   (r0_rdata),
        .r1_req     (r1_req),
        .r1_we      (r1_we),
        .r1_addr    (r1_addr),
        .r1_wdata   (r1_wdata),
        .r1_gnt     (r1_gnt),
        .r1_rvalid  (r1_rvalid),
        .r1_rdata   (r1_rdata),
`ifdef DMEM_ARB_STATS_EN
        .r0_grant_cnt (r0_grant_cnt),
        .r1_grant_cnt (r1_grant_cnt),
        .conflict_cnt (conflict_cnt),
`endif
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port memory: write at the edge, read data registered.
    always @(posedge clk) begin
        if (mem_write) mem_m[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem_m[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive(input logic q0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic q1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
        r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    endtask

    // Contention relief vectors: r1_req per cycle and expected winner (1 = loader).
    logic [7:0] rel_r1req = 8'b1111_1011;  // bit i = cycle i
    logic [7:0] rel_win   = 8'b1000_0000;

    initial begin
        logic exp1, prev0, prev1;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

        // Reset hold with both requesting.
        drive(1'b1, 1'b0, 8'h20, 8'h77, 1'b1, 1'b0, 8'h30, 8'h00);
        for (int i = 0; i < 3; i++) begin
            next_cyc(); settle();
            check_eq("rst_r0_gnt", r0_gnt, 0);
            check_eq("rst_r1_gnt", r1_gnt, 0);
            check_eq("rst_mem_rd", mem_read, 0);
            check_eq("rst_mem_wr", mem_write, 0);
            check_eq("rst_r0_rv", r0_rvalid, 0);
            check_eq("rst_r1_rv", r1_rvalid, 0);
        end

        // Continuous contention from reset release: r0 x4, r1, repeating.
        prev0 = 1'b0; prev1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) next_cyc();
            else begin next_cyc(); reset = 1'b1; end
            settle();
            exp1 = ((i % 5) == 4);
            check_eq("cont_r0_gnt", r0_gnt, !exp1);
            check_eq("cont_r1_gnt", r1_gnt, exp1);
            check_eq("cont_excl", r0_gnt & r1_gnt, 0);
            check_eq("cont_addr", mem_addr, exp1 ? 8'h30 : 8'h20);
            check_eq("cont_r0_rv", r0_rvalid, prev0);
            check_eq("cont_r1_rv", r1_rvalid, prev1);
            prev0 = !exp1; prev1 = exp1;
        end

        // Idle: no grants, port zeroed although inputs still carry addr/data.
        next_cyc();
        r0_req = 1'b0; r1_req = 1'b0;
        settle();
        check_eq("idle_r0_rv", r0_rvalid, 0);
        check_eq("idle_r1_rv", r1_rvalid, 1);
        check_eq("idle_gnt", {r0_gnt, r1_gnt}, 0);
        check_eq("idle_strb", {mem_read, mem_write}, 0);
        check_eq("idle_addr", mem_addr, 0);
        check_eq("idle_wdata", mem_wdata, 0);
`ifdef DMEM_ARB_STATS_EN
        check_eq("st_r0", r0_grant_cnt, 8);
        check_eq("st_r1", r1_grant_cnt, 2);
        check_eq("st_cf", conflict_cnt, 10);
`endif

        // Loader only: write 0x10 <- 0xA5 then read it back.
        next_cyc();
        drive(1'b0, 1'b0, 8'h20, 8'h77, 1'b1, 1'b1, 8'h10, 8'hA5);
        settle();
        check_eq("ld_wr_gnt1", r1_gnt, 1);
        check_eq("ld_wr_gnt0", r0_gnt, 0);
        check_eq("ld_wr_strb", {mem_read, mem_write}, 2'b01);
        check_eq("ld_wr_addr", mem_addr, 8'h10);
        check_eq("ld_wr_data", mem_wdata, 8'hA5);
        next_cyc();
        r1_we = 1'b0;
        settle();
        check_eq("ld_rd_gnt1", r1_gnt, 1);
        check_eq("ld_rd_strb", {mem_read, mem_write}, 2'b10);
        check_eq("ld_rd_addr", mem_addr, 8'h10);
        check_eq("ld_rd_rv_early", r1_rvalid, 0);
        next_cyc();
        r1_req = 1'b0;
        settle();
        check_eq("ld_rv", r1_rvalid, 1);
        check_eq("ld_rdata", r1_rdata, 8'hA5);
        check_eq("ld_r0_rv", r0_rvalid, 0);
        check_eq("ld_r0_rdata", r0_rdata, 0);

        // Core only: write 0x44 <- 0x3C then read it back.
        next_cyc();
        drive(1'b1, 1'b1, 8'h44, 8'h3C, 1'b0, 1'b0, 8'h10, 8'hA5);
        settle();
        check_eq("co_wr_gnt0", r0_gnt, 1);
        check_eq("co_wr_strb", {mem_read, mem_write}, 2'b01);
        check_eq("co_wr_addr", mem_addr, 8'h44);
        check_eq("co_wr_data", mem_wdata, 8'h3C);
        next_cyc();
        r0_we = 1'b0;
        settle();
        check_eq("co_rd_strb", {mem_read, mem_write}, 2'b10);
        next_cyc();
        r0_req = 1'b0;
        settle();
        check_eq("co_rv", r0_rvalid, 1);
        check_eq("co_rdata", r0_rdata, 8'h3C);
        check_eq("co_r1_rv", r1_rvalid, 0);
        check_eq("co_r1_rdata", r1_rdata, 0);

        // Contention relief: r1 drops after 2 contested grants, counter restarts.
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            drive(1'b1, 1'b0, 8'h20, 8'h00, rel_r1req[i], 1'b0, 8'h30, 8'h00);
            settle();
            check_eq("rel_r0_gnt", r0_gnt, !rel_win[i]);
            check_eq("rel_r1_gnt", r1_gnt, rel_win[i]);
        end
        next_cyc();
        r0_req = 1'b0; r1_req = 1'b0;
        settle();

        // Reset arriving at the edge that would launch the read's rvalid.
        next_cyc();
        drive(1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        settle();
        check_eq("mr_gnt", r0_gnt, 1);
        reset = 1'b0;
        r0_req = 1'b0;
        next_cyc(); settle();
        check_eq("mr_rv", r0_rvalid, 0);
        check_eq("mr_rdata", r0_rdata, 0);
        check_eq("mr_strb", {mem_read, mem_write}, 0);
        check_eq("mr_gnt_idle", {r0_gnt, r1_gnt}, 0);
        next_cyc();
        reset = 1'b1;
        settle();

        // Reset asserted while rvalid is already up drops it immediately.
        next_cyc();
        r0_req = 1'b1;
        settle();
        check_eq("mr2_gnt", r0_gnt, 1);
        next_cyc();
        r0_req = 1'b0;
        settle();
        check_eq("mr2_rv_pre", r0_rvalid, 1);
        reset = 1'b0;
        #1;
        check_eq("mr2_rv", r0_rvalid, 0);
        check_eq("mr2_rdata", r0_rdata, 0);
        next_cyc();
        reset = 1'b1;
        settle();

        // Loader alone right after reset is granted at once.
        next_cyc();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
        settle();
        check_eq("pr_r1_gnt", r1_gnt, 1);
        check_eq("pr_addr", mem_addr, 8'h10);
        next_cyc();
        r1_req = 1'b0;
        settle();

`ifdef DMEM_ARB_STATS_EN
        // Saturation: preload counters near the top, then contend.
        next_cyc();
        force dut.u_stats.r0_cnt_q = 16'hFFFE;
        force dut.u_stats.r1_cnt_q = 16'hFFFE;
        force dut.u_stats.cf_cnt_q = 16'hFFFE;
        #1;
        release dut.u_stats.r0_cnt_q;
        release dut.u_stats.r1_cnt_q;
        release dut.u_stats.cf_cnt_q;
        drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00);
        settle();
        for (int i = 0; i < 6; i++) begin
            next_cyc(); settle();
        end
        next_cyc();
        r0_req = 1'b0; r1_req = 1'b0;
        settle();
        check_eq("sat_r0", r0_grant_cnt, 16'hFFFF);
        check_eq("sat_r1", r1_grant_cnt, 16'hFFFF);
        check_eq("sat_cf", conflict_cnt, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
